// File: rtl/gpo_seq_pkg.sv
// Shared constants and types for the GPO pattern sequencer slot.
package gpo_seq_pkg;

    // Word addresses within the slot
    localparam logic [4:0] ADDR_CTRL     = 5'd0;
    localparam logic [4:0] ADDR_STATUS   = 5'd1;
    localparam logic [4:0] ADDR_LAST     = 5'd2;
    localparam logic [4:0] ADDR_DWELL    = 5'd3;
    localparam logic [4:0] ADDR_MANUAL   = 5'd4;
    localparam logic [4:0] ADDR_PAT_BASE = 5'd16;

    // CTRL bit positions
    localparam int CTRL_START = 0;
    localparam int CTRL_STOP  = 1;
    localparam int CTRL_LOOP  = 2;

    // STATUS bit positions
    localparam int STAT_BUSY    = 0;
    localparam int STAT_DONE    = 1;
    localparam int STAT_IDX_LSB = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Last count value of a step; a dwell of zero behaves like one.
    function automatic logic [31:0] dwell_last(input logic [31:0] dwell);
        return (dwell == 32'd0) ? 32'd0 : (dwell - 32'd1);
    endfunction

endpackage

// File: rtl/gpo_seq_if.sv
// Slot bus shared with the other I/O cores.
interface gpo_seq_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;

    modport master (
        output cs, read, write, addr, wr_data,
        input  rd_data
    );

    modport slave (
        input  cs, read, write, addr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/gpo_seq_timer.sv
// Dwell counter: counts cycles within a step and flags the last one.
module gpo_seq_timer
    import gpo_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] dwell,
    output logic        tick
);

    logic [31:0] cnt_q;
    logic [31:0] cnt_d;

    // Live compare against the current dwell so a shortened dwell acts at once
    assign tick = en && (cnt_q >= dwell_last(dwell));

    // Next count: clear wins, wrap to zero on the boundary, otherwise count up
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = 32'd0;
        end else if (en) begin
            if (tick) begin
                cnt_d = 32'd0;
            end else begin
                cnt_d = cnt_q + 32'd1;
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/gpo_seq_ctrl.sv
// GPO pattern sequencer: register file, two-state run FSM and registered output.
module gpo_seq_ctrl
    import gpo_seq_pkg::*;
#(
    parameter int W       = 16,
    parameter int N_STEPS = 8
) (
    input  logic          clk,
    input  logic          reset,
    gpo_seq_if.slave      bus,
    output logic [W-1:0]  dout
);

    localparam int         IW      = $clog2(N_STEPS);
    localparam logic [5:0] PAT_END = 6'(16 + N_STEPS);

    state_e          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic            loop_q, loop_d;
    logic            done_q, done_d;
    logic [IW-1:0]   last_q, last_d;
    logic [31:0]     dwell_q, dwell_d;
    logic [W-1:0]    manual_q, manual_d;
    logic [W-1:0]    pat_q [N_STEPS];
    logic [W-1:0]    pat_d [N_STEPS];
    logic [W-1:0]    dout_q, dout_d;

    logic            wr_en_s;
    logic            pat_hit_s;
    logic            start_s;
    logic            stop_s;
    logic            tick_s;
    logic            tmr_clr_s;
    logic            tmr_en_s;
    logic            unused_s;

    assign wr_en_s   = bus.cs && bus.write;
    assign pat_hit_s = bus.addr[4] && ({1'b0, bus.addr} < PAT_END);
    assign start_s   = wr_en_s && (bus.addr == ADDR_CTRL) && bus.wr_data[CTRL_START];
    assign stop_s    = wr_en_s && (bus.addr == ADDR_CTRL) && bus.wr_data[CTRL_STOP];

    // Reads have no side effects; the strobe is part of the slot bus only
    assign unused_s  = ^{bus.read, bus.wr_data};

    assign tmr_en_s  = (state_q == ST_RUN);
    assign tmr_clr_s = start_s || (state_q != ST_RUN);

    gpo_seq_timer u_timer (
        .clk   (clk),
        .reset (reset),
        .clr   (tmr_clr_s),
        .en    (tmr_en_s),
        .dwell (dwell_q),
        .tick  (tick_s)
    );

    // Software-visible configuration registers and pattern table writes
    always_comb begin
        loop_d   = loop_q;
        last_d   = last_q;
        dwell_d  = dwell_q;
        manual_d = manual_q;
        pat_d    = pat_q;
        if (wr_en_s) begin
            case (bus.addr)
                ADDR_CTRL:   loop_d   = bus.wr_data[CTRL_LOOP];
                ADDR_LAST:   last_d   = bus.wr_data[IW-1:0];
                ADDR_DWELL:  dwell_d  = bus.wr_data;
                ADDR_MANUAL: manual_d = bus.wr_data[W-1:0];
                default: begin
                    if (pat_hit_s) begin
                        pat_d[bus.addr[IW-1:0]] = bus.wr_data[W-1:0];
                    end else begin
                        pat_d = pat_q;
                    end
                end
            endcase
        end else begin
            loop_d = loop_q;
        end
    end

    // Run FSM: stop beats start, start (re)launches at step 0
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = done_q;
        if (stop_s) begin
            state_d = ST_IDLE;
        end else if (start_s) begin
            state_d = ST_RUN;
            idx_d   = '0;
            done_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_RUN: begin
                    if (tick_s) begin
                        // >= so a LAST lowered below idx still ends or wraps
                        if (idx_q >= last_q) begin
                            if (loop_q) begin
                                idx_d = '0;
                            end else begin
                                state_d = ST_IDLE;
                                done_d  = 1'b1;
                            end
                        end else begin
                            idx_d = idx_q + IW'(1);
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output from next-state values so it changes on the same edge as the state
    always_comb begin
        if (state_d == ST_RUN) begin
            dout_d = pat_d[idx_d];
        end else begin
            dout_d = manual_d;
        end
    end

    // Readback mux on address
    always_comb begin
        bus.rd_data = 32'd0;
        case (bus.addr)
            ADDR_STATUS: begin
                bus.rd_data[STAT_BUSY]                     = (state_q == ST_RUN);
                bus.rd_data[STAT_DONE]                     = done_q;
                bus.rd_data[STAT_IDX_LSB+3:STAT_IDX_LSB]  = 4'(idx_q);
            end
            ADDR_LAST:   bus.rd_data = 32'(last_q);
            ADDR_DWELL:  bus.rd_data = dwell_q;
            ADDR_MANUAL: bus.rd_data = 32'(manual_q);
            default: begin
                if (pat_hit_s) begin
                    bus.rd_data = 32'(pat_q[bus.addr[IW-1:0]]);
                end else begin
                    bus.rd_data = 32'd0;
                end
            end
        endcase
    end

    // State, configuration and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            loop_q   <= 1'b0;
            done_q   <= 1'b0;
            last_q   <= '0;
            dwell_q  <= 32'd0;
            manual_q <= '0;
            pat_q    <= '{default: '0};
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            loop_q   <= loop_d;
            done_q   <= done_d;
            last_q   <= last_d;
            dwell_q  <= dwell_d;
            manual_q <= manual_d;
            pat_q    <= pat_d;
            dout_q   <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_gpo_seq_ctrl.sv
// Directed self-checking bench for gpo_seq_ctrl (W=16, N_STEPS=8).
module tb_gpo_seq_ctrl;

    logic        clk;
    logic        reset;
    logic [15:0] dout;
    logic [31:0] rdv;
    logic [15:0] pat_exp [3];
    int          n_cmp;
    int          n_err;

    gpo_seq_if bus ();

    gpo_seq_ctrl #(.W(16), .N_STEPS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .dout  (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs      = 1'b1;
        bus.write   = 1'b1;
        bus.addr    = a;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.cs    = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rd_data;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp       = 0;
        n_err       = 0;
        pat_exp[0]  = 16'h0001;
        pat_exp[1]  = 16'h0002;
        pat_exp[2]  = 16'h0004;
        reset       = 1'b1;
        bus.cs      = 1'b0;
        bus.read    = 1'b0;
        bus.write   = 1'b0;
        bus.addr    = 5'd0;
        bus.wr_data = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        step();

        // Reset state
        chk("rst_dout", 32'(dout), 32'd0);
        rd(5'd0,  rdv); chk("rst_ctrl",   rdv, 32'd0);
        rd(5'd1,  rdv); chk("rst_status", rdv, 32'd0);
        rd(5'd2,  rdv); chk("rst_last",   rdv, 32'd0);
        step();
        rd(5'd3,  rdv); chk("rst_dwell",  rdv, 32'd0);
        rd(5'd4,  rdv); chk("rst_manual", rdv, 32'd0);
        rd(5'd16, rdv); chk("rst_pat0",   rdv, 32'd0);

        // Manual value appears the cycle after the write
        wr(5'd4, 32'h0000_A5A5);
        chk("manual_dout", 32'(dout), 32'h0000_A5A5);

        // Table load, upper bits of PAT0 dropped
        wr(5'd16, 32'hFFFF_0001);
        wr(5'd17, 32'h0000_0002);
        wr(5'd18, 32'h0000_0004);
        wr(5'd2,  32'h0000_0002);
        wr(5'd3,  32'h0000_0003);
        rd(5'd16, rdv); chk("pat0_trunc", rdv, 32'h0000_0001);
        rd(5'd17, rdv); chk("pat1_rb",    rdv, 32'h0000_0002);
        rd(5'd2,  rdv); chk("last_rb",    rdv, 32'h0000_0002);
        step();
        rd(5'd3,  rdv); chk("dwell_rb",   rdv, 32'h0000_0003);
        rd(5'd25, rdv); chk("unmapped",   rdv, 32'd0);

        // One-shot run: 1,1,1,2,2,2,4,4,4 then manual with done
        wr(5'd0, 32'h0000_0001);
        for (int k = 0; k < 9; k++) begin
            chk($sformatf("oneshot_dout_%0d", k), 32'(dout), 32'(pat_exp[k/3]));
            rd(5'd1, rdv);
            chk($sformatf("oneshot_stat_%0d", k), rdv, 32'(((k/3) << 4) | 1));
            step();
        end
        chk("oneshot_end_dout", 32'(dout), 32'h0000_A5A5);
        rd(5'd1, rdv);
        chk("oneshot_done", rdv & 32'h3, 32'h2);

        // Loop mode for 20 cycles, then stop
        wr(5'd0, 32'h0000_0005);
        for (int k = 0; k < 20; k++) begin
            chk($sformatf("loop_dout_%0d", k), 32'(dout), 32'(pat_exp[(k/3)%3]));
            if (k < 19) step();
        end
        wr(5'd0, 32'h0000_0002);
        chk("stop_dout", 32'(dout), 32'h0000_A5A5);
        rd(5'd1, rdv);
        chk("stop_status", rdv & 32'h3, 32'h0);

        // Start and stop together while idle stays idle
        wr(5'd0, 32'h0000_0003);
        chk("ss_dout", 32'(dout), 32'h0000_A5A5);
        rd(5'd1, rdv);
        chk("ss_busy", rdv & 32'h1, 32'h0);

        // DWELL=0, LAST=3: one cycle per step, four cycles busy
        wr(5'd19, 32'h0000_0008);
        wr(5'd3,  32'h0000_0000);
        wr(5'd2,  32'h0000_0003);
        wr(5'd0,  32'h0000_0001);
        chk("d0_dout_0", 32'(dout), 32'h1);
        rd(5'd1, rdv); chk("d0_busy_0", rdv & 32'h1, 32'h1);
        step(); chk("d0_dout_1", 32'(dout), 32'h2);
        step(); chk("d0_dout_2", 32'(dout), 32'h4);
        step(); chk("d0_dout_3", 32'(dout), 32'h8);
        rd(5'd1, rdv); chk("d0_busy_3", rdv & 32'h1, 32'h1);
        step(); chk("d0_dout_end", 32'(dout), 32'h0000_A5A5);
        rd(5'd1, rdv); chk("d0_done", rdv & 32'h3, 32'h2);

        // Restart at step 2
        wr(5'd3, 32'h0000_0003);
        wr(5'd2, 32'h0000_0002);
        wr(5'd0, 32'h0000_0001);
        repeat (6) step();
        chk("rs_at_step2", 32'(dout), 32'h4);
        wr(5'd0, 32'h0000_0001);
        chk("rs_dout_0", 32'(dout), 32'h1);
        step(); chk("rs_dout_1", 32'(dout), 32'h1);
        step(); chk("rs_dout_2", 32'(dout), 32'h1);
        step(); chk("rs_dout_3", 32'(dout), 32'h2);

        // Asynchronous reset in step 1
        reset = 1'b1;
        #1;
        chk("ar_dout", 32'(dout), 32'd0);
        rd(5'd1, rdv); chk("ar_status", rdv, 32'd0);
        rd(5'd3, rdv); chk("ar_dwell",  rdv, 32'd0);
        rd(5'd16, rdv); chk("ar_pat0",  rdv, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step();
        chk("ar_dout_after", 32'(dout), 32'd0);

        // Live DWELL shrink at cnt=51 and live pattern edit
        wr(5'd4,  32'h0000_A5A5);
        wr(5'd16, 32'h0000_0001);
        wr(5'd17, 32'h0000_0002);
        wr(5'd2,  32'h0000_0001);
        wr(5'd3,  32'd100);
        wr(5'd0,  32'h0000_0001);
        repeat (50) step();
        chk("live_pre", 32'(dout), 32'h1);
        wr(5'd3, 32'd10);
        chk("live_write_cycle", 32'(dout), 32'h1);
        step();
        chk("live_advance", 32'(dout), 32'h2);
        wr(5'd17, 32'h0000_00F0);
        chk("live_pat_edit", 32'(dout), 32'h00F0);
        rd(5'd1, rdv);
        chk("live_status", rdv, 32'h0000_0011);
        wr(5'd0, 32'h0000_0002);
        chk("live_stop", 32'(dout), 32'h0000_A5A5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
